// File: rtl/cdc_handshake_tx.sv
// Source side of a four-phase req/ack CDC handshake: holds the accepted word on
// data_out, raises req_out a cycle later and sequences against a synchronized ack_in.
module cdc_handshake_tx #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  req_out,
    input  logic                  ack_in,
    output logic                  busy,
    output logic                  done_tick,
    output logic                  timeout_tick
);

    localparam int unsigned     CW       = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_REQ,
        S_REL,
        S_DRAIN
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [SYNC_STAGES-1:0]  r_ack_sync;
    logic                    w_ack_s;
    logic [CW-1:0]           r_cnt;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_req;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_tmo;
    logic                    w_req_next;
    logic                    w_done;
    logic                    w_tmo;
    logic                    w_accept;
    logic                    w_tmo_hit;
    logic                    w_in_ready;

    assign w_ack_s    = r_ack_sync[SYNC_STAGES-1];
    assign w_in_ready = (r_state == S_IDLE) && !w_ack_s;
    assign w_tmo_hit  = (TIMEOUT_CYCLES != 0) && (r_cnt == TMO_LAST);

    assign in_ready     = w_in_ready;
    assign data_out     = r_data;
    assign req_out      = r_req;
    assign busy         = r_busy;
    assign done_tick    = r_done;
    assign timeout_tick = r_tmo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_in};
        end
    end

    // Normal exit is tested before the timeout so it wins on a coincident edge.
    always_comb begin
        w_next     = r_state;
        w_req_next = r_req;
        w_done     = 1'b0;
        w_tmo      = 1'b0;
        w_accept   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid && w_in_ready) begin
                    w_accept = 1'b1;
                    w_next   = S_SETUP;
                end
            end
            S_SETUP: begin
                w_req_next = 1'b1;
                w_next     = S_REQ;
            end
            S_REQ: begin
                if (w_ack_s) begin
                    w_req_next = 1'b0;
                    w_next     = S_REL;
                end else if (w_tmo_hit) begin
                    w_req_next = 1'b0;
                    w_tmo      = 1'b1;
                    w_next     = S_DRAIN;
                end
            end
            S_REL: begin
                if (!w_ack_s) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end else if (w_tmo_hit) begin
                    w_req_next = 1'b0;
                    w_tmo      = 1'b1;
                    w_next     = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_req_next = 1'b0;
                if (!w_ack_s) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_req_next = 1'b0;
                w_next     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_tmo   <= 1'b0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_req   <= w_req_next;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= w_done;
            r_tmo   <= w_tmo;
            if (w_accept) begin
                r_data <= in_data;
            end
            if (r_state == S_SETUP) begin
                r_cnt <= '0;
            end else if (r_state == S_REQ || r_state == S_REL) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench: DUT A (default timeout) for loopback/delayed-ack/reset cases,
// DUT B (TIMEOUT_CYCLES=16) for the abort paths.
module tb_cdc_handshake_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [7:0] a_in_data, a_data_out;
    logic       a_in_valid, a_in_ready, a_req_out, a_ack_in, a_busy, a_done, a_tmo;
    logic       a_loop, a_ack_man;
    assign a_ack_in = a_loop ? a_req_out : a_ack_man;

    logic [7:0] b_in_data, b_data_out;
    logic       b_in_valid, b_in_ready, b_req_out, b_ack_in, b_busy, b_done, b_tmo;

    int n_checks = 0;
    int n_errors = 0;

    cdc_handshake_tx #(
        .DATA_WIDTH    (8),
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(1024)
    ) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (a_in_data),
        .in_valid    (a_in_valid),
        .in_ready    (a_in_ready),
        .data_out    (a_data_out),
        .req_out     (a_req_out),
        .ack_in      (a_ack_in),
        .busy        (a_busy),
        .done_tick   (a_done),
        .timeout_tick(a_tmo)
    );

    cdc_handshake_tx #(
        .DATA_WIDTH    (8),
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(16)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (b_in_data),
        .in_valid    (b_in_valid),
        .in_ready    (b_in_ready),
        .data_out    (b_data_out),
        .req_out     (b_req_out),
        .ack_in      (b_ack_in),
        .busy        (b_busy),
        .done_tick   (b_done),
        .timeout_tick(b_tmo)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Loopback transfer on A; bit i of each mask is the value after edge Ei.
    task automatic xfer_loop_a(input logic [7:0] d);
        logic [7:0] e_req, e_done, e_busy;
        e_req  = 8'b0000_1110;
        e_done = 8'b1000_0000;
        e_busy = 8'b0111_1111;
        check("a_ready_pre", 32'(a_in_ready), 32'd1);
        a_in_data  = d;
        a_in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (i == 0) begin
                a_in_valid = 1'b0;
                check("a_data_E0", 32'(a_data_out), 32'(d));
            end
            check($sformatf("a_req_E%0d", i),  32'(a_req_out), 32'(e_req[i]));
            check($sformatf("a_done_E%0d", i), 32'(a_done),    32'(e_done[i]));
            check($sformatf("a_busy_E%0d", i), 32'(a_busy),    32'(e_busy[i]));
            check($sformatf("a_tmo_E%0d", i),  32'(a_tmo),     32'd0);
        end
        check("a_ready_E7", 32'(a_in_ready), 32'd1);
    endtask

    initial begin
        logic flag_a, flag_b, flag_c;

        rst_n      = 1'b1;
        a_in_data  = '0; a_in_valid = 1'b0; a_loop = 1'b1; a_ack_man = 1'b0;
        b_in_data  = '0; b_in_valid = 1'b0; b_ack_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_a_req",  32'(a_req_out),  32'd0);
        check("rst_a_data", 32'(a_data_out), 32'd0);
        check("rst_a_busy", 32'(a_busy),     32'd0);
        check("rst_a_done", 32'(a_done),     32'd0);
        check("rst_a_tmo",  32'(a_tmo),      32'd0);
        check("rst_b_req",  32'(b_req_out),  32'd0);
        check("rst_b_busy", 32'(b_busy),     32'd0);
        #20;
        @(negedge clk) rst_n = 1'b1;
        tick;
        check("post_rst_a_ready", 32'(a_in_ready), 32'd1);
        check("post_rst_b_ready", 32'(b_in_ready), 32'd1);

        // Loopback: A5 then 3C back to back, 8-cycle period
        xfer_loop_a(8'hA5);
        xfer_loop_a(8'h3C);
        tick;

        // Delayed responder: ack rise after 10 cycles, fall after 5
        a_loop = 1'b0; a_ack_man = 1'b0;
        a_in_data = 8'h96; a_in_valid = 1'b1;
        tick;
        a_in_valid = 1'b0;
        flag_a = a_busy;
        tick;
        check("dly_req_rise", 32'(a_req_out), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick;
            flag_a &= a_busy;
        end
        a_ack_man = 1'b1;
        tick; flag_a &= a_busy;
        tick; flag_a &= a_busy;
        check("dly_req_hold", 32'(a_req_out), 32'd1);
        tick; flag_a &= a_busy;
        check("dly_req_fall", 32'(a_req_out), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick;
            flag_a &= a_busy;
        end
        a_ack_man = 1'b0;
        tick; flag_a &= a_busy;
        tick; flag_a &= a_busy;
        check("dly_done_early", 32'(a_done), 32'd0);
        tick;
        check("dly_done", 32'(a_done), 32'd1);
        check("dly_busy_end", 32'(a_busy), 32'd0);
        check("dly_busy_all", 32'(flag_a), 32'd1);
        check("dly_data", 32'(a_data_out), 32'h96);
        tick;

        // in_valid held with changing in_data: only the next IDLE accept latches
        a_loop = 1'b1;
        a_in_data = 8'h11; a_in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            check($sformatf("hold_data_E%0d", i), 32'(a_data_out), 32'h11);
            if (i == 7) check("hold_done_E7", 32'(a_done), 32'd1);
            a_in_data = 8'(8'h20 + i);
        end
        tick;
        a_in_valid = 1'b0;
        check("hold_next_accept", 32'(a_data_out), 32'h27);
        for (int i = 0; i < 7; i++) tick;
        check("hold_next_done", 32'(a_done), 32'd1);
        tick;

        // Asynchronous reset mid-REQ
        a_in_data = 8'h5A; a_in_valid = 1'b1;
        tick;
        a_in_valid = 1'b0;
        tick;
        tick;
        check("mid_req_high", 32'(a_req_out), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req",  32'(a_req_out),  32'd0);
        check("async_rst_busy", 32'(a_busy),     32'd0);
        check("async_rst_data", 32'(a_data_out), 32'd0);
        #3 rst_n = 1'b1;
        tick;
        xfer_loop_a(8'hC3);

        // B: ack stuck 0, timeout 16 edges after entering REQ
        flag_b = 1'b0; flag_c = 1'b0;
        b_ack_in = 1'b0;
        b_in_data = 8'h4B; b_in_valid = 1'b1;
        tick;
        b_in_valid = 1'b0;
        check("to0_data", 32'(b_data_out), 32'h4B);
        tick;
        check("to0_req", 32'(b_req_out), 32'd1);
        for (int i = 2; i <= 16; i++) begin
            tick;
            flag_b |= b_tmo;
            flag_c |= b_done;
        end
        check("to0_tmo_early", 32'(flag_b), 32'd0);
        check("to0_req_hold", 32'(b_req_out), 32'd1);
        tick;
        check("to0_tmo",  32'(b_tmo),     32'd1);
        check("to0_req",  32'(b_req_out), 32'd0);
        check("to0_busy", 32'(b_busy),    32'd1);
        check("to0_done", 32'(b_done),    32'd0);
        tick;
        flag_c |= b_done;
        check("to0_idle_busy",  32'(b_busy),     32'd0);
        check("to0_tmo_pulse",  32'(b_tmo),      32'd0);
        check("to0_idle_ready", 32'(b_in_ready), 32'd1);
        check("to0_no_done",    32'(flag_c),     32'd0);
        check("to0_data_held",  32'(b_data_out), 32'h4B);

        // B: ack rises then sticks 1, timeout in REL, drain until release
        flag_b = 1'b0; flag_c = 1'b0;
        b_in_data = 8'hE1; b_in_valid = 1'b1;
        tick;
        b_in_valid = 1'b0;
        tick;
        check("to1_req", 32'(b_req_out), 32'd1);
        b_ack_in = 1'b1;
        tick;
        tick;
        check("to1_req_hold", 32'(b_req_out), 32'd1);
        tick;
        check("to1_req_fall", 32'(b_req_out), 32'd0);
        for (int i = 5; i <= 16; i++) begin
            tick;
            flag_b |= b_tmo;
            flag_c |= b_done;
        end
        check("to1_tmo_early", 32'(flag_b), 32'd0);
        tick;
        check("to1_tmo",   32'(b_tmo),      32'd1);
        check("to1_busy",  32'(b_busy),     32'd1);
        check("to1_ready", 32'(b_in_ready), 32'd0);
        flag_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            flag_b |= b_in_ready;
            flag_c |= b_done;
        end
        check("to1_ready_drain", 32'(flag_b), 32'd0);
        b_ack_in = 1'b0;
        tick; flag_c |= b_done;
        tick; flag_c |= b_done;
        check("to1_drain_busy", 32'(b_busy), 32'd1);
        tick; flag_c |= b_done;
        check("to1_idle_busy",  32'(b_busy),     32'd0);
        check("to1_idle_ready", 32'(b_in_ready), 32'd1);
        check("to1_no_done",    32'(flag_c),     32'd0);
        check("to1_data_held",  32'(b_data_out), 32'hE1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
